// File: rtl/imem_loader.sv
// Boot loader that streams a byte-framed program (header, big-endian words, XOR checksum)
// into instruction memory and releases the CPU once the image checks out.
module imem_loader #(
  parameter int DataSize = 32,
  parameter int PCsize   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                imem_we,
  output logic [PCsize-1:0]   imem_waddr,
  output logic [DataSize-1:0] imem_wdata,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                cpu_run
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE, ERR} state_e;

  state_e              state_q;
  logic [PCsize-1:0]   wordCnt_q;
  logic [PCsize-1:0]   lastIdx_q;
  logic [1:0]          byteCnt_q;
  logic [7:0]          chk_q;
  logic [23:0]         shift_q;
  logic                we_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic [PCsize-1:0]   waddr_q;
  logic [DataSize-1:0] wdata_q;

  logic                xfer;
  logic                hdrOver;
  logic [31:0]         word_d;

  assign xfer    = in_valid && busy_q;
  assign hdrOver = (in_data >> PCsize) != 8'd0;
  assign word_d  = {shift_q, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wordCnt_q <= '0;
      lastIdx_q <= '0;
      byteCnt_q <= '0;
      chk_q     <= '0;
      shift_q   <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_q   <= HDR;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            wordCnt_q <= '0;
            byteCnt_q <= '0;
            chk_q     <= '0;
          end
        end
        HDR: begin
          if (xfer) begin
            chk_q <= in_data;
            if (hdrOver) begin
              state_q <= ERR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              state_q   <= DATA;
              lastIdx_q <= PCsize'(in_data);
            end
          end
        end
        DATA: begin
          if (xfer) begin
            chk_q     <= chk_q ^ in_data;
            byteCnt_q <= byteCnt_q + 2'd1;
            if (byteCnt_q == 2'd3) begin
              we_q    <= 1'b1;
              waddr_q <= wordCnt_q;
              wdata_q <= DataSize'(word_d);
              // The counter parks on the last index so a full 2^PCsize image never wraps
              if (wordCnt_q == lastIdx_q) state_q <= CHK;
              else wordCnt_q <= wordCnt_q + 1'b1;
            end else begin
              shift_q <= {shift_q[15:0], in_data};
            end
          end
        end
        CHK: begin
          if (xfer) begin
            busy_q <= 1'b0;
            if (in_data == chk_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = busy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_run    = done_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good loads, bad header, full-size image with bad
// checksum, reset mid-load and a gappy stream with a stray start.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_run;

  int assertCount = 0;
  int failCount   = 0;
  int readyDrops  = 0;

  logic [5:0]  wrAddr[$];
  logic [31:0] wrData[$];

  imem_loader #(.DataSize(32), .PCsize(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_run    (cpu_run)
  );

  always #5 clk = ~clk;

  // Record every write strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      wrAddr.push_back(imem_waddr);
      wrData.push_back(imem_wdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    if (in_ready !== 1'b1) readyDrops++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    readyDrops = 0;
  endtask

  initial begin
    logic [7:0] s2Bytes [8];
    logic [7:0] s6Bytes [8];
    logic [31:0] expWord;
    s2Bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    s6Bytes = s2Bytes;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_busy",     32'(busy),     32'd0);
    checkOutput("rst_done",     32'(done),     32'd0);
    checkOutput("rst_error",    32'(error),    32'd0);
    checkOutput("rst_cpu_run",  32'(cpu_run),  32'd0);
    checkOutput("rst_we",       32'(imem_we),  32'd0);
    rst_n = 1'b1;

    // Single word DEADBEEF, checksum 22
    clearLog();
    pulseStart();
    checkOutput("s1_busy",     32'(busy),     32'd1);
    checkOutput("s1_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(8'h00, 0);
    applyStimulus(8'hDE, 0);
    applyStimulus(8'hAD, 0);
    applyStimulus(8'hBE, 0);
    applyStimulus(8'hEF, 0);
    checkOutput("s1_we_pulse", 32'(imem_we), 32'd1);
    applyStimulus(8'h22, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("s1_nwrites", 32'(wrAddr.size()), 32'd1);
    checkOutput("s1_addr0",   32'(wrAddr.size() > 0 ? wrAddr[0] : 6'bx), 32'd0);
    checkOutput("s1_data0",   wrAddr.size() > 0 ? wrData[0] : 32'bx, 32'hDEADBEEF);
    checkOutput("s1_done",    32'(done),    32'd1);
    checkOutput("s1_cpu_run", 32'(cpu_run), 32'd1);
    checkOutput("s1_error",   32'(error),   32'd0);
    checkOutput("s1_busy",    32'(busy),    32'd0);

    // Two words back-to-back, checksum 89
    clearLog();
    pulseStart();
    checkOutput("s2_done_cleared", 32'(done), 32'd0);
    applyStimulus(8'h01, 0);
    for (int i = 0; i < 8; i++) applyStimulus(s2Bytes[i], 0);
    applyStimulus(8'h89, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("s2_nwrites",    32'(wrAddr.size()), 32'd2);
    checkOutput("s2_addr0",      32'(wrAddr.size() > 0 ? wrAddr[0] : 6'bx), 32'd0);
    checkOutput("s2_data0",      wrAddr.size() > 0 ? wrData[0] : 32'bx, 32'h11223344);
    checkOutput("s2_addr1",      32'(wrAddr.size() > 1 ? wrAddr[1] : 6'bx), 32'd1);
    checkOutput("s2_data1",      wrAddr.size() > 1 ? wrData[1] : 32'bx, 32'h55667788);
    checkOutput("s2_ready_drops", 32'(readyDrops), 32'd0);
    checkOutput("s2_done",       32'(done), 32'd1);

    // Header 40 exceeds 64 words
    clearLog();
    pulseStart();
    applyStimulus(8'h40, 0);
    checkOutput("s3_error",    32'(error),    32'd1);
    checkOutput("s3_in_ready", 32'(in_ready), 32'd0);
    checkOutput("s3_busy",     32'(busy),     32'd0);
    checkOutput("s3_done",     32'(done),     32'd0);
    in_valid = 1'b1; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("s3_error_held", 32'(error), 32'd1);
    checkOutput("s3_nwrites",    32'(wrAddr.size()), 32'd0);

    // Full 64-word image, bytes 0..255 (XOR 00), wrong checksum C0 instead of 3F
    clearLog();
    pulseStart();
    applyStimulus(8'h3F, 0);
    for (int i = 0; i < 256; i++) applyStimulus(8'(i), 0);
    applyStimulus(8'hC0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("s4_nwrites", 32'(wrAddr.size()), 32'd64);
    for (int k = 0; k < 64; k++) begin
      expWord = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      checkOutput($sformatf("s4_addr%0d", k), 32'(k < wrAddr.size() ? wrAddr[k] : 6'bx), 32'(k));
      checkOutput($sformatf("s4_data%0d", k), k < wrAddr.size() ? wrData[k] : 32'bx, expWord);
    end
    checkOutput("s4_error",   32'(error),   32'd1);
    checkOutput("s4_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("s4_done",    32'(done),    32'd0);

    // Reset after two data bytes, then a clean reload
    clearLog();
    pulseStart();
    applyStimulus(8'h00, 0);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'hBB, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s5_in_ready", 32'(in_ready),   32'd0);
    checkOutput("s5_busy",     32'(busy),       32'd0);
    checkOutput("s5_error",    32'(error),      32'd0);
    checkOutput("s5_done",     32'(done),       32'd0);
    checkOutput("s5_cpu_run",  32'(cpu_run),    32'd0);
    checkOutput("s5_we",       32'(imem_we),    32'd0);
    checkOutput("s5_waddr",    32'(imem_waddr), 32'd0);
    checkOutput("s5_wdata",    imem_wdata,      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("s5_nwrites_abort", 32'(wrAddr.size()), 32'd0);
    checkOutput("s5_idle_busy",     32'(busy), 32'd0);
    pulseStart();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h03, 0);
    applyStimulus(8'h04, 0);
    applyStimulus(8'h04, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("s5_nwrites", 32'(wrAddr.size()), 32'd1);
    checkOutput("s5_data0",   wrAddr.size() > 0 ? wrData[0] : 32'bx, 32'h01020304);
    checkOutput("s5_done",    32'(done), 32'd1);

    // Same two-word image as before, with random gaps and a stray start mid-DATA
    clearLog();
    pulseStart();
    applyStimulus(8'h01, int'($urandom_range(0, 2)));
    for (int i = 0; i < 3; i++) applyStimulus(s6Bytes[i], int'($urandom_range(0, 2)));
    pulseStart();
    checkOutput("s6_busy_after_start", 32'(busy), 32'd1);
    for (int i = 3; i < 8; i++) applyStimulus(s6Bytes[i], int'($urandom_range(0, 3)));
    applyStimulus(8'h89, int'($urandom_range(0, 2)));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("s6_nwrites", 32'(wrAddr.size()), 32'd2);
    checkOutput("s6_addr0",   32'(wrAddr.size() > 0 ? wrAddr[0] : 6'bx), 32'd0);
    checkOutput("s6_data0",   wrAddr.size() > 0 ? wrData[0] : 32'bx, 32'h11223344);
    checkOutput("s6_addr1",   32'(wrAddr.size() > 1 ? wrAddr[1] : 6'bx), 32'd1);
    checkOutput("s6_data1",   wrAddr.size() > 1 ? wrData[1] : 32'bx, 32'h55667788);
    checkOutput("s6_done",    32'(done),  32'd1);
    checkOutput("s6_error",   32'(error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DataSize, default 32, instruction word width in bits.
REQ-002 SHALL have parameter PCsize, default 6, instruction memory address width; capacity is 2^PCsize words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse that begins a program load.
REQ-006 SHALL have port in_valid  input  1  byte-stream data valid.
REQ-007 SHALL have port in_data  input  8  byte-stream payload.
REQ-008 SHALL have port in_ready  output  1  loader can accept a byte; a byte transfers when in_valid and in_ready are both high at a rising clk edge.
REQ-009 SHALL have port imem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-010 SHALL have port imem_waddr  output  PCsize  word address of the current write.
REQ-011 SHALL have port imem_wdata  output  DataSize  instruction word being written.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  last load finished with a matching checksum; held until the next start.
REQ-014 SHALL have port error  output  1  last load failed; held until the next start.
REQ-015 SHALL have port cpu_run  output  1  high only while done is high; gates PC advance.

Function
REQ-016 SHALL implement states IDLE, HDR, DATA, CHK, DONE, ERR.
REQ-017 SHALL move IDLE, DONE or ERR to HDR on start, clearing done, error, word counter, byte counter and checksum; start in HDR, DATA or CHK SHALL be ignored.
REQ-018 SHALL drive in_ready high exactly in HDR, DATA and CHK, and busy high in the same states.
REQ-019 SHALL treat the HDR byte as word count minus 1: bits [PCsize-1:0] give N-1, so N is 1..2^PCsize; any nonzero bit above PCsize-1 SHALL go to ERR; otherwise go to DATA.
REQ-020 SHALL assemble each word from 4 consecutive accepted DATA bytes, big-endian: the first byte goes to bits [31:24].
REQ-021 SHALL pulse imem_we for exactly one cycle, the cycle after the 4th byte of a word is accepted, with imem_wdata equal to the assembled word and imem_waddr equal to the word index (first word is 0).
REQ-022 SHALL keep imem_waddr and imem_wdata stable while imem_we is high; their values are don't-care otherwise.
REQ-023 SHALL keep accepting bytes during a write pulse; byte N+1 of the stream may arrive in the cycle imem_we is high.
REQ-024 SHALL go to CHK after the 4th byte of word N-1 is accepted; the final write pulse SHALL still be issued.
REQ-025 SHALL keep a running checksum equal to the 8-bit XOR of the HDR byte and all DATA bytes.
REQ-026 SHALL compare the CHK byte with the checksum: equal goes to DONE (done=1), unequal goes to ERR (error=1); no imem write in either case.
REQ-027 SHALL leave state and counters unchanged in cycles with no transfer; there is no timeout.
REQ-028 SHALL ignore in_valid in IDLE, DONE and ERR.
REQ-029 SHALL keep the word counter at PCsize bits with no wrap; N=2^PCsize writes addresses 0..2^PCsize-1 exactly once.

Reset
REQ-030 SHALL, while rst_n is low and independent of clk, force IDLE and drive in_ready, imem_we, busy, done, error and cpu_run to 0, with imem_waddr, imem_wdata, the byte counter and checksum at 0.
REQ-031 SHALL abort a load in progress on reset assertion with no further imem writes; words already written SHALL remain in memory.
REQ-032 SHALL take its first state change on the first rising clk edge after rst_n deasserts.

Verification
REQ-033 Bench: start; bytes 00, DE AD BE EF, checksum 00^DE^AD^BE^EF=22 -> one imem_we, addr 0, data DEADBEEF; then done=1, cpu_run=1.
REQ-034 Bench: header 01 (N=2), 8 data bytes sent back-to-back with in_valid held high -> writes at addr 0 and addr 1 in order, in_ready never drops; then done=1.
REQ-035 Bench: header 40 with PCsize=6 -> ERR, error=1, no imem_we, in_ready=0 afterward.
REQ-036 Bench: header 3F, 256 bytes of data, wrong checksum -> 64 writes (addr 0..63), then error=1, cpu_run=0.
REQ-037 Bench: rst_n pulled low after 2 of 4 data bytes -> all outputs 0 immediately, no write; a new start then reloads correctly.
REQ-038 Bench: start pulsed during DATA, and in_valid toggled randomly -> start ignored, words and addresses unchanged versus the no-gap run.
